uart_rx_fifo: RTL and testbench

Byte buffer placed directly downstream of the UART receiver. It captures each byte flagged by the receiver's one-cycle `receive_sig` strobe and holds it in a small circular FIFO. Bytes are presented to the system-bus side through a valid/ready handshake, so a busy consumer does not lose back-to-back 19200-baud frames. Overruns are dropped, flagged and counted.

---
 rtl/uart_rx_fifo.sv | 92 +++++++++
 tb/tb_uart_rx_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Byte FIFO sitting behind the UART receiver: captures strobed bytes, presents them
// show-ahead over valid/ready, and drops/counts bytes that arrive while full.
module uart_rx_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [7:0]        wr_data,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [7:0]        rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              clr_overflow,
    output logic [7:0]        drop_count
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] rp_q, rp_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_count_q, drop_count_d;
    logic              pop, push, drop;

    // Status flags come straight from the count register, never from the handshake inputs.
    assign full       = (count_q == DEPTH_C);
    assign empty      = (count_q == '0);
    assign rd_valid   = !empty;
    assign rd_data    = mem_q[rp_q];
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

    always_comb begin
        pop          = rd_valid & rd_ready;
        push         = wr_valid & (!full | pop);
        drop         = wr_valid & full & !pop;
        wp_d         = wp_q;
        rp_d         = rp_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (push) wp_d = wp_q + ADDR_W'(1);
        if (pop)  rp_d = rp_q + ADDR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        if (clr_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
        // A drop in the same cycle as a clear wins, so the clear restarts the count at one.
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_overflow)
                drop_count_d = 8'd1;
            else if (drop_count_q != 8'hFF)
                drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q         <= '0;
            rp_q         <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            if (push) mem_q[wp_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: a vector table for the basic
// push/pop/overflow flow plus hand sequences for wrap, saturation and async reset.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clr_overflow;
    logic [7:0] drop_count;

    int checks   = 0;
    int failures = 0;

    uart_rx_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic       clr;
        int         cnt;
        logic [7:0] data;
        logic       chk;
        logic       ov;
        int         drops;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic wv, input logic [7:0] wd, input logic rr, input logic clr,
                          input int cnt, input logic [7:0] data, input logic chk,
                          input logic ov, input int drops);
        vec_t v;
        v.wv = wv; v.wd = wd; v.rr = rr; v.clr = clr; v.cnt = cnt;
        v.data = data; v.chk = chk; v.ov = ov; v.drops = drops;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkStatus(input string tag, input int cnt, input logic ov, input int drops);
        checkOutput({tag, " count"},      32'(count),      32'(cnt));
        checkOutput({tag, " full"},       32'(full),       32'(cnt == 8));
        checkOutput({tag, " empty"},      32'(empty),      32'(cnt == 0));
        checkOutput({tag, " rd_valid"},   32'(rd_valid),   32'(cnt != 0));
        checkOutput({tag, " overflow"},   32'(overflow),   32'(ov));
        checkOutput({tag, " drop_count"}, 32'(drop_count), 32'(drops));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wv, input logic [7:0] wd, input logic rr, input logic clr);
        wr_valid     = wv;
        wr_data      = wd;
        rd_ready     = rr;
        clr_overflow = clr;
        tick();
        wr_valid     = 1'b0;
        rd_ready     = 1'b0;
        clr_overflow = 1'b0;
    endtask

    logic [7:0] model[$];
    int         sent;
    int         got;
    int         cycles;

    initial begin
        reset        = 1'b0;
        wr_valid     = 1'b0;
        wr_data      = '0;
        rd_ready     = 1'b0;
        clr_overflow = 1'b0;
        #12;
        checkStatus("reset", 0, 1'b0, 0);
        checkOutput("reset rd_data", 32'(rd_data), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Separated strobes, then drain; then fill, overflow, push-while-full-with-pop, drain, clear.
        addVec(1, 8'h41, 0, 0, 1, 8'h41, 1, 0, 0);
        addVec(0, 8'h00, 0, 0, 1, 8'h41, 1, 0, 0);
        addVec(1, 8'h42, 0, 0, 2, 8'h41, 1, 0, 0);
        addVec(0, 8'h00, 0, 0, 2, 8'h41, 1, 0, 0);
        addVec(1, 8'h43, 0, 0, 3, 8'h41, 1, 0, 0);
        addVec(0, 8'h00, 1, 0, 2, 8'h42, 1, 0, 0);
        addVec(0, 8'h00, 1, 0, 1, 8'h43, 1, 0, 0);
        addVec(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);
        addVec(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 8; i++) addVec(1, 8'(i), 0, 0, i + 1, 8'h00, 1, 0, 0);
        addVec(1, 8'hFF, 0, 0, 8, 8'h00, 1, 1, 1);
        addVec(1, 8'hAA, 1, 0, 8, 8'h01, 1, 1, 1);
        for (int i = 2; i < 8; i++) addVec(0, 8'h00, 1, 0, 9 - i, 8'(i), 1, 1, 1);
        addVec(0, 8'h00, 1, 0, 1, 8'hAA, 1, 1, 1);
        addVec(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 1);
        addVec(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].clr);
            checkStatus(tag, vecs[i].cnt, vecs[i].ov, vecs[i].drops);
            if (vecs[i].chk) checkOutput({tag, " rd_data"}, 32'(rd_data), 32'(vecs[i].data));
        end

        // Wrap-around with random consumer stalls, checked against a queue model.
        sent   = 0;
        got    = 0;
        cycles = 0;
        while ((sent < 20 || model.size() != 0) && cycles < 300) begin
            logic pop_m;
            logic push_m;
            checkOutput("wrap rd_valid", 32'(rd_valid), 32'(model.size() != 0));
            if (model.size() != 0) checkOutput("wrap rd_data", 32'(rd_data), 32'(model[0]));
            rd_ready = ($urandom_range(0, 3) != 0);
            pop_m    = rd_ready && model.size() != 0;
            push_m   = (sent < 20) && (model.size() < 8 || pop_m);
            wr_valid = push_m;
            wr_data  = 8'(8'h10 + sent);
            tick();
            if (pop_m) begin
                checkOutput("wrap order", 32'(model[0]), 32'(8'h10 + got));
                void'(model.pop_front());
                got++;
            end
            if (push_m) begin
                model.push_back(8'(8'h10 + sent));
                sent++;
            end
            wr_valid = 1'b0;
            rd_ready = 1'b0;
            cycles++;
        end
        checkOutput("wrap all received", 32'(got), 32'd20);
        checkStatus("wrap end", 0, 1'b0, 0);

        // Saturating drop counter and clear-versus-drop priority.
        for (int i = 0; i < 8; i++) applyStimulus(1, 8'(8'h80 + i), 0, 0);
        checkStatus("refill", 8, 1'b0, 0);
        for (int i = 0; i < 300; i++) applyStimulus(1, 8'hEE, 0, 0);
        checkStatus("300 drops", 8, 1'b1, 255);
        checkOutput("300 drops head", 32'(rd_data), 32'h80);
        applyStimulus(0, 8'h00, 0, 1);
        checkStatus("clr alone", 8, 1'b0, 0);
        applyStimulus(1, 8'hEE, 0, 0);
        applyStimulus(1, 8'hEE, 0, 0);
        checkStatus("two drops", 8, 1'b1, 2);
        applyStimulus(1, 8'hEE, 0, 1);
        checkStatus("clr with drop", 8, 1'b1, 1);

        // Async reset between edges with five bytes loaded.
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 0);
        checkStatus("five loaded", 5, 1'b1, 1);
        checkOutput("five loaded head", 32'(rd_data), 32'h83);
        #2;
        reset = 1'b0;
        #1;
        checkStatus("async reset", 0, 1'b0, 0);
        checkOutput("async reset rd_data", 32'(rd_data), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1, 8'h5A, 0, 0);
        checkStatus("post reset push", 1, 1'b0, 0);
        checkOutput("post reset rd_data", 32'(rd_data), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
